proc_control_fsm: RTL and testbench

- Instruction-sequencing control unit sitting directly upstream of the 9-bit register-array datapath.
- Captures a 9-bit instruction from DIN into its internal IR and steps through time slots T0..T3.
- Drives the datapath's one-hot bus-source selects, register load enables, Ain, Gin and AddSub.
- Signals Done on the last step of each instruction.

---
 rtl/proc_control_fsm.sv | 110 +++++++++++
 tb/tb_proc_control_fsm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_control_fsm.sv
// Instruction sequencer for the 9-bit register-array datapath: captures an
// instruction in T0, then decodes IR and state into the datapath control strobes.
//
//   state | meaning
//   T0    | idle / fetch, capture DIN into IR when Run is high
//   T1    | mv, mvi or nop complete here; add/sub load A from Rx
//   T2    | add/sub: drive Ry, load G with A +/- bus
//   T3    | add/sub: write G back to Rx
module proc_control_fsm #(
  parameter int IW = 9
) (
  input  logic          Clock,
  input  logic          rst,
  input  logic          Run,
  input  logic [IW-1:0] DIN,
  output logic [7:0]    Rout,
  output logic [7:0]    Rin,
  output logic          Gout,
  output logic          DINout,
  output logic          Ain,
  output logic          Gin,
  output logic          AddSub,
  output logic          Done,
  output logic [IW-1:0] IR,
  output logic [1:0]    Tstep
);

  localparam logic [1:0] S_T0 = 2'd0;
  localparam logic [1:0] S_T1 = 2'd1;
  localparam logic [1:0] S_T2 = 2'd2;
  localparam logic [1:0] S_T3 = 2'd3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [IW-1:0] r_ir;
  logic [2:0]    w_op;
  logic [7:0]    w_x_sel;
  logic [7:0]    w_y_sel;

  // Field positions are fixed by the instruction encoding, not by IW.
  assign w_op    = r_ir[8:6];
  assign w_x_sel = 8'(1) << r_ir[5:3];
  assign w_y_sel = 8'(1) << r_ir[2:0];

  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      r_state <= S_T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_T0 && Run) r_ir <= DIN;
    end
  end

  always_comb begin
    w_next = S_T0;
    Rout   = '0;
    Rin    = '0;
    Gout   = 1'b0;
    DINout = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    case (r_state)
      S_T0: if (Run) w_next = S_T1;
      S_T1: begin
        case (w_op)
          OP_MV: begin
            Rout = w_y_sel;
            Rin  = w_x_sel;
            Done = 1'b1;
          end
          OP_MVI: begin
            DINout = 1'b1;
            Rin    = w_x_sel;
            Done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Rout   = w_x_sel;
            Ain    = 1'b1;
            w_next = S_T2;
          end
          default: Done = 1'b1;
        endcase
      end
      S_T2: begin
        Rout   = w_y_sel;
        Gin    = 1'b1;
        AddSub = (w_op == OP_SUB);
        w_next = S_T3;
      end
      S_T3: begin
        Gout = 1'b1;
        Rin  = w_x_sel;
        Done = 1'b1;
      end
      default: w_next = S_T0;
    endcase
  end

  assign IR    = r_ir;
  assign Tstep = r_state;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: a behavioural datapath driven by the DUT strobes,
// compared against an architectural register-file model.
module tb_proc_control_fsm;

  logic       Clock;
  logic       rst;
  logic       Run;
  logic [8:0] DIN;
  logic [7:0] Rout, Rin;
  logic       Gout, DINout, Ain, Gin, AddSub, Done;
  logic [8:0] IR;
  logic [1:0] Tstep;

  proc_control_fsm #(.IW(9)) dut (
    .Clock(Clock), .rst(rst), .Run(Run), .DIN(DIN),
    .Rout(Rout), .Rin(Rin), .Gout(Gout), .DINout(DINout),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done),
    .IR(IR), .Tstep(Tstep)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int done_cyc   = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // Datapath driven purely by the control strobes.
  logic [8:0] dp_r [8] = '{default: '0};
  logic [8:0] dp_a = '0;
  logic [8:0] dp_g = '0;
  logic [8:0] dp_bus;

  always_comb begin
    dp_bus = '0;
    for (int i = 0; i < 8; i++) if (Rout[i]) dp_bus = dp_bus | dp_r[i];
    if (Gout)   dp_bus = dp_bus | dp_g;
    if (DINout) dp_bus = dp_bus | DIN;
  end

  always @(posedge Clock) begin
    for (int i = 0; i < 8; i++) if (Rin[i]) dp_r[i] <= dp_bus;
    if (Ain) dp_a <= dp_bus;
    if (Gin) dp_g <= AddSub ? dp_a - dp_bus : dp_a + dp_bus;
  end

  // Architectural reference.
  logic [8:0]  ref_r [8] = '{default: '0};
  logic [21:0] snap [4];

  function automatic logic [21:0] ctl();
    return {Rout, Rin, Gout, DINout, Ain, Gin, AddSub, Done};
  endfunction

  task automatic exec(input logic [8:0] ins, input logic [8:0] imm, input bit noise);
    logic [2:0] op, x, y;
    int lat, exp_lat;
    bit done_seen;
    op = ins[8:6]; x = ins[5:3]; y = ins[2:0];
    exp_lat = (op == 3'b010 || op == 3'b011) ? 4 : 2;
    for (int i = 0; i < 4; i++) snap[i] = '1;
    compared++;
    if (Tstep !== 2'd0) begin
      mismatched++; $display("FAIL start_t0: Tstep=%0d want 0", Tstep);
    end
    Run = 1'b1; DIN = ins;
    @(posedge Clock); #1;
    lat = 1; done_seen = 0;
    for (int k = 0; k < 6 && !done_seen; k++) begin
      lat++;
      Run = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      DIN = (op == 3'b001) ? imm : (noise ? 9'($urandom) : ins);
      #1;
      snap[Tstep] = ctl();
      compared++;
      if ($countones({Rout, Gout, DINout}) > 1 || $countones(Rin) > 1) begin
        mismatched++; $display("FAIL onehot: Rout=%b Gout=%b DINout=%b Rin=%b", Rout, Gout, DINout, Rin);
      end
      compared++;
      if (IR !== ins) begin
        mismatched++; $display("FAIL ir_stable: IR=%b want %b", IR, ins);
      end
      if (Done) begin
        done_seen = 1; done_cyc = cyc; Run = 1'b0;
      end
      @(posedge Clock); #1;
    end
    compared++;
    if (!done_seen || lat != exp_lat) begin
      mismatched++; $display("FAIL latency ins=%b: got %0d (done=%0d) want %0d", ins, lat, done_seen, exp_lat);
    end
    compared++;
    if (Tstep !== 2'd0 || ctl() !== 22'd0) begin
      mismatched++; $display("FAIL t0_idle: Tstep=%0d ctl=%h want 0/0", Tstep, ctl());
    end
    case (op)
      3'b000: ref_r[x] = ref_r[y];
      3'b001: ref_r[x] = imm;
      3'b010: ref_r[x] = 9'(ref_r[x] + ref_r[y]);
      3'b011: ref_r[x] = 9'(ref_r[x] - ref_r[y]);
      default: ;
    endcase
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (dp_r[i] !== ref_r[i]) begin
        mismatched++; $display("FAIL reg R%0d after %b: got %h want %h", i, ins, dp_r[i], ref_r[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; Run = 1'b1; DIN = 9'b001000000;
    repeat (3) @(posedge Clock);
    #1;
    compared++;
    if (Tstep !== 2'd0 || IR !== 9'd0 || ctl() !== 22'd0) begin
      mismatched++; $display("FAIL reset_hold: Tstep=%0d IR=%b ctl=%h want 0", Tstep, IR, ctl());
    end
    Run = 1'b0;
    #2 rst = 1'b1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    compared++;
    if (Tstep !== 2'd0 || IR !== 9'd0) begin
      mismatched++; $display("FAIL reset_release: Tstep=%0d IR=%b want 0 0", Tstep, IR);
    end
  endtask

  task automatic test_mvi_mv();
    exec(9'b001000000, 9'd5, 0);
    compared++;
    if (snap[1] !== {8'h00, 8'h01, 6'b010001}) begin
      mismatched++; $display("FAIL mvi_t1: got %h want %h", snap[1], {8'h00, 8'h01, 6'b010001});
    end
    exec(9'b000111000, 9'd0, 0);
    compared++;
    if (snap[1] !== {8'h01, 8'h80, 6'b000001}) begin
      mismatched++; $display("FAIL mv_t1: got %h want %h", snap[1], {8'h01, 8'h80, 6'b000001});
    end
    compared++;
    if (dp_r[7] !== 9'd5) begin
      mismatched++; $display("FAIL mv_r7: got %h want 005", dp_r[7]);
    end
  endtask

  task automatic test_add_sub();
    exec(9'b001001000, 9'd3, 0);
    exec(9'b010000001, 9'd0, 0);
    compared++;
    if (snap[1] !== {8'h01, 8'h00, 6'b001000} || snap[2] !== {8'h02, 8'h00, 6'b000100}
        || snap[3] !== {8'h00, 8'h01, 6'b100001}) begin
      mismatched++; $display("FAIL add_steps: got %h %h %h", snap[1], snap[2], snap[3]);
    end
    compared++;
    if (dp_r[0] !== 9'd8) begin
      mismatched++; $display("FAIL add_result: R0=%h want 008", dp_r[0]);
    end
    exec(9'b011000001, 9'd0, 0);
    compared++;
    if (snap[1][1] !== 1'b0 || snap[2] !== {8'h02, 8'h00, 6'b000110} || snap[3][1] !== 1'b0) begin
      mismatched++; $display("FAIL sub_steps: got %h %h %h", snap[1], snap[2], snap[3]);
    end
    compared++;
    if (dp_r[0] !== 9'd5) begin
      mismatched++; $display("FAIL sub_result: R0=%h want 005", dp_r[0]);
    end
    exec(9'b001010000, 9'd0, 0);
    exec(9'b001011000, 9'd1, 0);
    exec(9'b011010011, 9'd0, 0);
    compared++;
    if (dp_r[2] !== 9'h1FF) begin
      mismatched++; $display("FAIL sub_wrap: R2=%h want 1ff", dp_r[2]);
    end
  endtask

  task automatic test_robust();
    exec(9'b010000001, 9'd0, 1);
    exec(9'b001100000, 9'd77, 0);
    begin
      int first_done;
      first_done = done_cyc;
      exec(9'b010100000, 9'd0, 0);
      compared++;
      if (done_cyc - first_done != 4) begin
        mismatched++; $display("FAIL back_to_back: gap=%0d want 4", done_cyc - first_done);
      end
    end
    exec(9'b110010011, 9'd0, 0);
    compared++;
    if (snap[1] !== {8'h00, 8'h00, 6'b000001}) begin
      mismatched++; $display("FAIL nop_t1: got %h want 000001", snap[1]);
    end
    exec(9'b000011011, 9'd0, 0);
    compared++;
    if (snap[1] !== {8'h08, 8'h08, 6'b000001}) begin
      mismatched++; $display("FAIL mv_same: got %h", snap[1]);
    end
    exec(9'b010010010, 9'd0, 0);
  endtask

  task automatic test_reset_mid();
    Run = 1'b1; DIN = 9'b010000001;
    @(posedge Clock); #1;
    Run = 1'b0;
    @(posedge Clock); #1;
    compared++;
    if (Tstep !== 2'd2) begin
      mismatched++; $display("FAIL mid_reach_t2: Tstep=%0d want 2", Tstep);
    end
    #2 rst = 1'b0;
    #1;
    compared++;
    if (Tstep !== 2'd0 || IR !== 9'd0 || ctl() !== 22'd0) begin
      mismatched++; $display("FAIL mid_reset_async: Tstep=%0d IR=%b ctl=%h want 0", Tstep, IR, ctl());
    end
    @(posedge Clock); #3 rst = 1'b1;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    compared++;
    if (dp_r[0] !== ref_r[0] || Tstep !== 2'd0) begin
      mismatched++; $display("FAIL mid_reset_r0: R0=%h Tstep=%0d want %h 0", dp_r[0], Tstep, ref_r[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) exec({3'b001, 3'(i), 3'b000}, 9'($urandom), 0);
    for (int n = 0; n < 40; n++)
      exec({3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom)}, 9'($urandom),
           1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_mvi_mv();
    test_add_sub();
    test_robust();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
